bus_fabric: RTL and testbench

//  Parametrised single-master, NUM_SLAVES-slave memory bus between the CPU data port and memory-mapped slaves (data memory, peripherals).

---
 rtl/bus_fabric_pkg.sv | 23 ++
 rtl/bus_fabric_if.sv | 34 +++
 rtl/bus_fabric_addr_decoder.sv | 30 +++
 rtl/bus_fabric.sv | 166 ++++++++++++++++
 tb/tb_bus_fabric.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the bus fabric: FSM state encoding, error
// read-data pattern and width helpers used by the fabric and its decoder.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_RESP   = 2'd2,
    BUS_ERR    = 2'd3
  } bus_state_e;

  localparam logic [63:0] BUS_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // Slave index width; a single-slave build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return ($clog2(t) > 5) ? $clog2(t) : 5;
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Bus bundle between CPU data port, fabric and slaves. 'master' is the fabric's
// CPU-facing port view, 'slave' is its view of the shared slave-side signals.
interface bus_fabric_if #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int NUM_SLAVES = 2
);

  logic [ADDR_W-1:0]            m_address;
  logic [DATA_W-1:0]            m_WriteData;
  logic                         m_MemWrite;
  logic                         m_MemRead;
  logic [DATA_W-1:0]            m_ReadData;
  logic                         m_ready;
  logic                         m_error;

  logic [ADDR_W-1:0]            s_address;
  logic [DATA_W-1:0]            s_WriteData;
  logic [NUM_SLAVES-1:0]        s_MemWrite;
  logic [NUM_SLAVES-1:0]        s_MemRead;
  logic [NUM_SLAVES*DATA_W-1:0] s_ReadData;
  logic [NUM_SLAVES-1:0]        s_ready;

  modport master (
    input  m_address, m_WriteData, m_MemWrite, m_MemRead,
    output m_ReadData, m_ready, m_error
  );

  modport slave (
    output s_address, s_WriteData, s_MemWrite, s_MemRead,
    input  s_ReadData, s_ready
  );

endinterface

// File: rtl/bus_fabric_addr_decoder.sv
// Combinational base/mask address decoder: hit flag plus the index of the
// lowest-numbered matching slave.
module bus_addr_decoder
  import bus_fabric_pkg::*;
#(
  parameter int                           ADDR_W     = 64,
  parameter int                           NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int                           IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scanning from the top down lets the lowest matching index overwrite last.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, NUM_SLAVES-slave memory bus fabric with registered response.
// Define BUS_FABRIC_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without s_ready.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                           ADDR_W     = 64,
  parameter int                           DATA_W     = 64,
  parameter int                           NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {64'h1000_0000, 64'h0},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {~64'hFF, ~64'hFFF}
`ifdef BUS_FABRIC_TIMEOUT_EN
  ,
  parameter int                           TIMEOUT_CYCLES = 16
`endif
) (
  input logic          clk,
  input logic          rst,
  bus_fabric_if.master m_bus,
  bus_fabric_if.slave  s_bus
);

  localparam int                IDX_W    = idx_width(NUM_SLAVES);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(BUS_ERR_DATA);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              req;

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  bus_addr_decoder #(
    .ADDR_W    (ADDR_W),
    .NUM_SLAVES(NUM_SLAVES),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK),
    .IDX_W     (IDX_W)
  ) u_decoder (
    .addr_i(m_bus.m_address),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  assign req = m_bus.m_MemRead | m_bus.m_MemWrite;

  // Only the latched slave's ready and read data are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready = s_bus.s_ready[i];
        sel_rdata = s_bus.s_ReadData[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
`ifdef BUS_FABRIC_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      BUS_IDLE: begin
`ifdef BUS_FABRIC_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (req) begin
          addr_d  = m_bus.m_address;
          wdata_d = m_bus.m_WriteData;
          write_d = m_bus.m_MemWrite;
          sel_d   = dec_idx;
          // Ambiguous op or no decode hit never reaches a slave.
          if ((m_bus.m_MemRead && m_bus.m_MemWrite) || !dec_hit) begin
            state_d = BUS_ERR;
          end else begin
            state_d = BUS_ACCESS;
          end
        end
      end
      BUS_ACCESS: begin
`ifdef BUS_FABRIC_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (sel_ready) begin
          rdata_d = write_q ? '0 : sel_rdata;
          state_d = BUS_RESP;
        end
`ifdef BUS_FABRIC_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = BUS_ERR;
        end
`endif
      end
      BUS_RESP: state_d = BUS_IDLE;
      BUS_ERR:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q <= BUS_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
`ifdef BUS_FABRIC_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
`ifdef BUS_FABRIC_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    m_bus.m_ready    = (state_q == BUS_RESP) || (state_q == BUS_ERR);
    m_bus.m_error    = (state_q == BUS_ERR);
    m_bus.m_ReadData = '0;
    if (state_q == BUS_RESP) begin
      m_bus.m_ReadData = rdata_q;
    end else if (state_q == BUS_ERR) begin
      m_bus.m_ReadData = ERR_DATA;
    end
  end

  always_comb begin
    s_bus.s_address   = addr_q;
    s_bus.s_WriteData = wdata_q;
    s_bus.s_MemRead   = '0;
    s_bus.s_MemWrite  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if ((state_q == BUS_ACCESS) && (sel_q == IDX_W'(i))) begin
        s_bus.s_MemRead[i]  = !write_q;
        s_bus.s_MemWrite[i] = write_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: stimulus pushes expected responses, a
// negedge monitor pops and compares on every m_ready.
module tb_bus_fabric;
  import bus_fabric_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int NS     = 2;
  localparam logic [63:0] ERR_D = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_fabric_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NS)) bus ();

  bus_fabric #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_SLAVES(NS),
    .SLAVE_BASE({64'h1000_0000, 64'h0}),
    .SLAVE_MASK({~64'hFF, ~64'hFFF})
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .m_bus(bus),
    .s_bus(bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          lat[NS];
  logic [63:0] sdata[NS];
  int          acc[NS];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: ready after lat[i] strobe cycles (lat 0 = never ready).
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      acc[i] <= (bus.s_MemRead[i] | bus.s_MemWrite[i]) ? acc[i] + 1 : 0;
    end
  end

  always_comb begin
    bus.s_ready    = '0;
    bus.s_ReadData = '0;
    for (int i = 0; i < NS; i++) begin
      bus.s_ready[i] = (bus.s_MemRead[i] | bus.s_MemWrite[i]) && (lat[i] != 0) && (acc[i] >= lat[i] - 1);
      bus.s_ReadData[i*DATA_W +: DATA_W] = sdata[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && !rst) begin
      if (bus.m_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_ready", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_data", bus.m_ReadData, mon_e.data);
          check("resp_error", 64'(bus.m_error), 64'(mon_e.err));
          check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        check("idle_rdata", bus.m_ReadData, 64'd0);
        check("idle_error", 64'(bus.m_error), 64'd0);
      end
    end
  end

  task automatic do_req(input logic [63:0] addr, input logic [63:0] wdata,
                        input logic rd, input logic wr,
                        input logic [63:0] exp_data, input logic exp_err, input int exp_lat,
                        output int strb_cyc, output logic [1:0] rd_seen, output logic [1:0] wr_seen);
    exp_t e;
    bit   done;
    done     = 1'b0;
    strb_cyc = 0;
    rd_seen  = '0;
    wr_seen  = '0;
    @(posedge clk);
    #1;
    bus.m_address   = addr;
    bus.m_WriteData = wdata;
    bus.m_MemRead   = rd;
    bus.m_MemWrite  = wr;
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc + exp_lat;
    sb_q.push_back(e);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.m_ready === 1'b1) begin
        done = 1'b1;
      end else if ((|bus.s_MemRead) || (|bus.s_MemWrite)) begin
        strb_cyc++;
        rd_seen |= bus.s_MemRead;
        wr_seen |= bus.s_MemWrite;
      end
    end
    if (!done) check("req_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.m_MemRead  = 1'b0;
    bus.m_MemWrite = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_ready"}, 64'(bus.m_ready), 64'd0);
    check({tag, "_m_error"}, 64'(bus.m_error), 64'd0);
    check({tag, "_m_rdata"}, bus.m_ReadData, 64'd0);
    check({tag, "_s_read"}, 64'(bus.s_MemRead), 64'd0);
    check({tag, "_s_write"}, 64'(bus.s_MemWrite), 64'd0);
    check({tag, "_s_addr"}, bus.s_address, 64'd0);
    check({tag, "_s_wdata"}, bus.s_WriteData, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         sc;
    logic [1:0] rs, ws;
    exp_t       e;
    bus.m_address   = '0;
    bus.m_WriteData = '0;
    bus.m_MemRead   = 1'b0;
    bus.m_MemWrite  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      lat[i]   = 1;
      sdata[i] = '0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Read slave0, ready in first ACCESS cycle: m_ready two cycles after request.
    lat[0] = 1; sdata[0] = 64'hA5;
    do_req(64'h10, 64'h0, 1'b1, 1'b0, 64'hA5, 1'b0, 2, sc, rs, ws);
    check("t1_strobe_cycles", 64'(sc), 64'd1);
    check("t1_read_strobe", 64'(rs), 64'b01);
    check("t1_write_strobe", 64'(ws), 64'b00);
    check("t1_s_address", bus.s_address, 64'h10);

    // Write slave1 with a 3-cycle slave: write data returns 0.
    lat[1] = 3;
    do_req(64'h1000_0008, 64'h1234, 1'b0, 1'b1, 64'h0, 1'b0, 4, sc, rs, ws);
    check("t2_strobe_cycles", 64'(sc), 64'd3);
    check("t2_write_strobe", 64'(ws), 64'b10);
    check("t2_read_strobe", 64'(rs), 64'b00);
    check("t2_s_wdata", bus.s_WriteData, 64'h1234);

    // Unmapped address.
    do_req(64'h2000_0000, 64'h0, 1'b1, 1'b0, ERR_D, 1'b1, 1, sc, rs, ws);
    check("t3_strobe_cycles", 64'(sc), 64'd0);

    // Read and write together.
    do_req(64'h0, 64'h0, 1'b1, 1'b1, ERR_D, 1'b1, 1, sc, rs, ws);
    check("t4_strobe_cycles", 64'(sc), 64'd0);

    // Region edges: last byte of each window hits, first byte past misses.
    sdata[0] = 64'h0FFF_CAFE;
    do_req(64'hFFF, 64'h0, 1'b1, 1'b0, 64'h0FFF_CAFE, 1'b0, 2, sc, rs, ws);
    check("edge0_read_strobe", 64'(rs), 64'b01);
    do_req(64'h1000, 64'h0, 1'b1, 1'b0, ERR_D, 1'b1, 1, sc, rs, ws);
    check("edge0_miss_strobes", 64'(sc), 64'd0);
    lat[1] = 2; sdata[1] = 64'h55AA;
    do_req(64'h1000_00FF, 64'h0, 1'b1, 1'b0, 64'h55AA, 1'b0, 3, sc, rs, ws);
    check("edge1_read_strobe", 64'(rs), 64'b10);
    check("edge1_strobe_cycles", 64'(sc), 64'd2);
    do_req(64'h1000_0100, 64'h0, 1'b1, 1'b0, ERR_D, 1'b1, 1, sc, rs, ws);
    check("edge1_miss_strobes", 64'(sc), 64'd0);

    // Request held across m_ready: back-to-back transactions 3 cycles apart.
    lat[0] = 1; sdata[0] = 64'h77;
    @(posedge clk);
    #1;
    bus.m_address = 64'h20;
    bus.m_MemRead = 1'b1;
    e.data = 64'h77; e.err = 1'b0;
    e.cyc = cyc + 2; sb_q.push_back(e);
    e.cyc = cyc + 5; sb_q.push_back(e);
    repeat (5) @(posedge clk);
    #1;
    bus.m_MemRead = 1'b0;
    repeat (2) @(posedge clk);

`ifdef BUS_FABRIC_TIMEOUT_EN
    // Slave never ready: strobe for TIMEOUT_CYCLES cycles, then error.
    lat[0] = 0;
    do_req(64'h40, 64'h0, 1'b1, 1'b0, ERR_D, 1'b1, 17, sc, rs, ws);
    check("t5_strobe_cycles", 64'(sc), 64'd16);
    check("t5_read_strobe", 64'(rs), 64'b01);
`endif

    // Stalled access, then reset pulse aborts it without a response.
    lat[0] = 0;
    @(posedge clk);
    #1;
    bus.m_address = 64'h8;
    bus.m_MemRead = 1'b1;
`ifdef BUS_FABRIC_TIMEOUT_EN
    repeat (5) @(posedge clk);
`else
    repeat (100) @(posedge clk);
`endif
    #1;
    check("stall_read_strobe", 64'(bus.s_MemRead), 64'b01);
    check("stall_no_ready", 64'(bus.m_ready), 64'd0);
    rst = 1'b1;
    bus.m_MemRead = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("abort");

    lat[0] = 1; sdata[0] = 64'h99;
    do_req(64'h30, 64'h0, 1'b1, 1'b0, 64'h99, 1'b0, 2, sc, rs, ws);
    check("t6_read_strobe", 64'(rs), 64'b01);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
